// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES chunks with a registered carry
// between them, and every stage moves under a single global advance enable.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: operands still to be consumed, partial sum, carry into next chunk.
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];
    logic             r_ovf;
    logic             r_zero;

    logic             w_adv;
    logic             w_v_in   [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_s_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic [CW:0]      w_chunk  [STAGES];
    logic [WIDTH-1:0] w_s_nxt  [STAGES];
    logic             w_ovf_nxt;
    logic             w_zero_nxt;

    assign w_adv    = !r_vld[LAST] || out_ready;
    assign in_ready = w_adv;

    // Stage inputs and chunk additions; stage 0 takes the ports, later stages their predecessor.
    always_comb begin
        w_v_in[0] = in_valid;
        w_a_in[0] = a;
        w_b_in[0] = sub ? ~b : b;
        w_s_in[0] = '0;
        w_c_in[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            w_v_in[k] = r_vld[k-1];
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_s_in[k] = r_s[k-1];
            w_c_in[k] = r_c[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            w_chunk[k] = (CW+1)'(w_a_in[k][k*CW +: CW])
                       + (CW+1)'(w_b_in[k][k*CW +: CW])
                       + (CW+1)'(w_c_in[k]);
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*CW +: CW] = w_chunk[k][CW-1:0];
        end
        // Carry into the MSB is recovered from the MSB sum bit and the two operand MSBs.
        w_zero_nxt = (w_s_nxt[LAST] == '0);
        w_ovf_nxt  = w_chunk[LAST][CW] ^ (w_s_nxt[LAST][WIDTH-1]
                                         ^ w_a_in[LAST][WIDTH-1]
                                         ^ w_b_in[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_v_in[k];
                if (w_v_in[k]) begin
                    r_a[k] <= w_a_in[k];
                    r_b[k] <= w_b_in[k];
                    r_s[k] <= w_s_nxt[k];
                    r_c[k] <= w_chunk[k][CW];
                end
            end
            if (w_v_in[LAST]) begin
                r_ovf  <= w_ovf_nxt;
                r_zero <= w_zero_nxt;
            end
        end
    end

    assign out_valid = r_vld[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32-bit/4-stage instance with random traffic and
// backpressure, plus an 8-bit single-stage instance for directed corner cases.
module tb_pipelined_adder;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, sub, out_valid, out_ready, cout, overflow, zero;
    logic [W-1:0] a, b, sum;

    logic         in_valid8, in_ready8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
    logic [7:0]   a8, b8, sum8;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .overflow(ovf8), .zero(zero8)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic done;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t   e;
        longint r;
        if (s) begin
            e.sum  = x - y;
            e.cout = (x >= y);
            r      = longint'($signed(x)) - longint'($signed(y));
        end else begin
            e.sum  = x + y;
            e.cout = ((64'(x) + 64'(y)) >> W) != 64'd0;
            r      = longint'($signed(x)) + longint'($signed(y));
        end
        e.ovf  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.zero = (e.sum == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one operation from posedge+1, waits for acceptance, records the expected result.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int t;
        t        = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sub      = s;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        else q.push_back(model(x, y, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t         = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("drain_remaining", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                       input logic [10:0] exp);
        in_valid8 = 1'b1;
        a8        = x;
        b8        = y;
        sub8      = s;
        @(negedge clk);
        check("s1_in_ready", 64'(in_ready8), 64'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check("s1_out_valid", 64'(out_valid8), 64'd1);
        check("s1_result", 64'({sum8, cout8, ovf8, zero8}), 64'(exp));
        @(negedge clk);
        check("s1_no_dup", 64'(out_valid8), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops and compares on each output handshake, and checks outputs hold during stalls.
    initial begin
        logic hold_prev;
        exp_t held;
        exp_t e;
        hold_prev = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev)
                    check("stall_hold", 64'({out_valid, sum, cout, overflow, zero}),
                          64'({1'b1, held}));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check("unexpected_result", 64'(out_valid), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("result", 64'({sum, cout, overflow, zero}), 64'(e));
                    end
                end
                hold_prev = out_valid && !out_ready;
                held      = {sum, cout, overflow, zero};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0;
        done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_flags", 64'({sum, cout, overflow, zero}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid8", 64'(out_valid8), 64'd0);
        @(posedge clk);
        #1;

        // Latency of the first result with 1 + 0xFFFFFFFF
        issue(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency", 64'(lat), 64'(S));
        @(posedge clk);
        #1;
        issue(32'h8000_0000, 32'h0000_0001, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) issue($urandom, $urandom, 1'($urandom));
        drain();

        // Fill the pipe with the consumer stalled, hold five cycles, then release.
        out_ready = 1'b0;
        for (int i = 0; i < int'(S); i++) issue($urandom, $urandom, 1'($urandom));
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        drain();

        // Random bubbles and random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    issue($urandom, $urandom, 1'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        drain();

        // Reset with three operations in flight: none of them may emerge.
        for (int i = 0; i < 3; i++) issue($urandom, $urandom, 1'($urandom));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        repeat (6) begin
            @(negedge clk);
            check("rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(32'h1234_5678, 32'h1234_5678, 1'b1);
        drain();

        // Single-stage 8-bit instance: {sum, cout, ovf, zero}
        op8(8'h7F, 8'h01, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0});
        op8(8'h00, 8'h01, 1'b1, {8'hFF, 1'b0, 1'b0, 1'b0});
        op8(8'h80, 8'h01, 1'b1, {8'h7F, 1'b1, 1'b1, 1'b0});
        op8(8'hFF, 8'h01, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
